// File: rtl/run_monitor.sv
// ---------------------------------------------------------------------------
// run_monitor
//
// Watches a CPU from reset until it halts, counting run cycles, then walks
// the register-file debug read port and streams every entry out over a
// valid/ready channel. An optional watchdog forces the dump if the CPU never
// halts.
//
// Optional feature macro: RUN_MONITOR_STALL_CNT_EN
//   defined   -> stall_cycles counts SEND cycles with dump_ready low
//   undefined -> stall_cycles is tied to 0 and no counter is built
//
// Parameters:
//   CNT_W        width of the saturating cycle counters
//   NUM_REGS     number of register entries to dump (>= 1)
//   IDX_W        register index width, 2**IDX_W >= NUM_REGS
//   DATA_W       register data width
//   HALT_CONFIRM consecutive is_halted cycles needed to accept halt (>= 1)
//   TIMEOUT      run-cycle limit before a forced dump, 0 disables it
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   is_halted    CPU halt indication (only looked at while running)
//   rf_addr      register-file debug read address
//   rf_data      combinational read data for rf_addr
//   dump_valid   dump entry available
//   dump_ready   consumer accepts the entry
//   dump_idx     index of the current entry
//   dump_data    value of the current entry
//   total_cycle  run cycles counted, frozen once the dump starts
//   done         dump finished, sticky until reset
//   timed_out    dump was forced by the watchdog, sticky until reset
//   stall_cycles backpressure cycle count (see macro above)
// ---------------------------------------------------------------------------
module run_monitor #(
  parameter int CNT_W        = 32,
  parameter int NUM_REGS     = 32,
  parameter int IDX_W        = 5,
  parameter int DATA_W       = 32,
  parameter int HALT_CONFIRM = 1,
  parameter int TIMEOUT      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_halted,
  output logic [IDX_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic [CNT_W-1:0]  total_cycle,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  stall_cycles
);

  // halt_cnt only ever needs to reach HALT_CONFIRM-1 before the FSM leaves RUN
  localparam int HC_W = (HALT_CONFIRM > 1) ? $clog2(HALT_CONFIRM) : 1;
  localparam logic [HC_W-1:0]  HALT_LAST = HC_W'(HALT_CONFIRM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

  // Keep TIMEOUT-1 non-negative when the watchdog is disabled
  localparam int               TO_M1   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [HC_W-1:0]   halt_cnt;
  logic [HC_W-1:0]   halt_cnt_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [CNT_W-1:0]  total_next;
  logic              timed_out_next;
  logic [IDX_W-1:0]  dump_idx_next;
  logic [DATA_W-1:0] dump_data_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      total_cycle <= '0;
      halt_cnt    <= '0;
      idx         <= '0;
      dump_idx    <= '0;
      dump_data   <= '0;
      timed_out   <= 1'b0;
    end else begin
      state       <= state_next;
      total_cycle <= total_next;
      halt_cnt    <= halt_cnt_next;
      idx         <= idx_next;
      dump_idx    <= dump_idx_next;
      dump_data   <= dump_data_next;
      timed_out   <= timed_out_next;
    end
  end

  always_comb begin
    state_next     = state;
    total_next     = total_cycle;
    halt_cnt_next  = halt_cnt;
    idx_next       = idx;
    timed_out_next = timed_out;
    dump_idx_next  = dump_idx;
    dump_data_next = dump_data;
    rf_addr        = idx;
    dump_valid     = 1'b0;
    done           = 1'b0;

    case (state)
      ST_RUN: begin
        rf_addr       = '0;
        halt_cnt_next = is_halted ? halt_cnt + 1'b1 : '0;
        // Halt is checked first so it wins over a watchdog expiring on the
        // same edge; total_cycle is left untouched on the accepting edge.
        if (is_halted && (halt_cnt == HALT_LAST)) begin
          state_next    = ST_LOAD;
          idx_next      = '0;
          halt_cnt_next = '0;
        end else if (TO_EN && (total_cycle == TO_LAST)) begin
          total_next     = TO_VAL;
          timed_out_next = 1'b1;
          state_next     = ST_LOAD;
          idx_next       = '0;
          halt_cnt_next  = '0;
        end else if (total_cycle != '1) begin
          total_next = total_cycle + 1'b1;
        end
      end

      ST_LOAD: begin
        // rf_data answers rf_addr (== idx) combinationally in this cycle
        dump_data_next = rf_data;
        dump_idx_next  = idx;
        state_next     = ST_SEND;
      end

      ST_SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = ST_LOAD;
          end
        end
      end

      ST_DONE: begin
        done = 1'b1;
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

`ifdef RUN_MONITOR_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Counts only while an entry is offered and refused; never moves in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if ((state == ST_SEND) && !dump_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_run_monitor
//
// Self-checking bench for run_monitor. Three instances share one clock:
//   a: default parameters (32 x 32-bit dump, no watchdog)
//   b: HALT_CONFIRM=3, TIMEOUT=20, four entries
//   c: 4-bit counter, two 8-bit entries, for saturation and the short dump
// Only one instance is released from reset at a time.
// ---------------------------------------------------------------------------
module tb_run_monitor;

  typedef struct {
    logic        halted;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_total;
    logic        exp_timed_out;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } entry_t;

`ifdef RUN_MONITOR_STALL_CNT_EN
  localparam int EXP_STALL = 5;
`else
  localparam int EXP_STALL = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int     vectors     = 0;
  int     miscompares = 0;
  entry_t sb[$];

  // instance a
  logic        reset_a, is_halted_a, dump_ready_a, dump_valid_a, done_a, timed_out_a;
  logic [4:0]  rf_addr_a, dump_idx_a;
  logic [31:0] rf_data_a, dump_data_a, total_cycle_a, stall_cycles_a;
  logic [31:0] rf_a [32];
  always_comb rf_data_a = rf_a[rf_addr_a];

  // instance b
  logic        reset_b, is_halted_b, dump_ready_b, dump_valid_b, done_b, timed_out_b;
  logic [1:0]  rf_addr_b, dump_idx_b;
  logic [31:0] rf_data_b, dump_data_b, total_cycle_b, stall_cycles_b;
  logic [31:0] rf_b [4];
  always_comb rf_data_b = rf_b[rf_addr_b];

  // instance c
  logic        reset_c, is_halted_c, dump_ready_c, dump_valid_c, done_c, timed_out_c;
  logic [0:0]  rf_addr_c, dump_idx_c;
  logic [7:0]  rf_data_c, dump_data_c;
  logic [3:0]  total_cycle_c, stall_cycles_c;
  logic [7:0]  rf_c [2];
  always_comb rf_data_c = rf_c[rf_addr_c];

  run_monitor u_dut_a (
    .clk(clk), .reset(reset_a), .is_halted(is_halted_a),
    .rf_addr(rf_addr_a), .rf_data(rf_data_a),
    .dump_valid(dump_valid_a), .dump_ready(dump_ready_a),
    .dump_idx(dump_idx_a), .dump_data(dump_data_a),
    .total_cycle(total_cycle_a), .done(done_a), .timed_out(timed_out_a),
    .stall_cycles(stall_cycles_a)
  );

  run_monitor #(
    .CNT_W(32), .NUM_REGS(4), .IDX_W(2), .DATA_W(32),
    .HALT_CONFIRM(3), .TIMEOUT(20)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .is_halted(is_halted_b),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b),
    .dump_valid(dump_valid_b), .dump_ready(dump_ready_b),
    .dump_idx(dump_idx_b), .dump_data(dump_data_b),
    .total_cycle(total_cycle_b), .done(done_b), .timed_out(timed_out_b),
    .stall_cycles(stall_cycles_b)
  );

  run_monitor #(
    .CNT_W(4), .NUM_REGS(2), .IDX_W(1), .DATA_W(8),
    .HALT_CONFIRM(1), .TIMEOUT(0)
  ) u_dut_c (
    .clk(clk), .reset(reset_c), .is_halted(is_halted_c),
    .rf_addr(rf_addr_c), .rf_data(rf_data_c),
    .dump_valid(dump_valid_c), .dump_ready(dump_ready_c),
    .dump_idx(dump_idx_c), .dump_data(dump_data_c),
    .total_cycle(total_cycle_c), .done(done_c), .timed_out(timed_out_c),
    .stall_cycles(stall_cycles_c)
  );

  // Distinct register contents: multiplying by an odd constant is a bijection
  function automatic logic [31:0] rf_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_00FF;
  endfunction

  // Step to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one table row into instance b, clock it, and compare
  task automatic applyStimulus(input vec_t v, input int row);
    is_halted_b  = v.halted;
    dump_ready_b = v.ready;
    tick();
    checkOutput($sformatf("b_row%0d_valid", row), dump_valid_b, v.exp_valid);
    checkOutput($sformatf("b_row%0d_total", row), total_cycle_b, v.exp_total);
    checkOutput($sformatf("b_row%0d_timed_out", row), timed_out_b, v.exp_timed_out);
  endtask

  task automatic push_b();
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back('{idx: 5'(i), data: rf_val(100 + i)});
  endtask

  task automatic push_a();
    sb.delete();
    for (int i = 0; i < 32; i++) sb.push_back('{idx: 5'(i), data: rf_val(i)});
  endtask

  // Drain instance b with ready held high, comparing against the scoreboard
  task automatic drain_b(input string tag);
    int     got;
    entry_t e;
    got          = 0;
    dump_ready_b = 1'b1;
    for (int c = 0; c < 50 && !done_b; c++) begin
      if (dump_valid_b) begin
        got++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput({tag, "_idx"}, 64'(dump_idx_b), 64'(e.idx));
          checkOutput({tag, "_data"}, dump_data_b, e.data);
        end
      end
      tick();
    end
    checkOutput({tag, "_count"}, got, 4);
    checkOutput({tag, "_done"}, done_b, 1);
    checkOutput({tag, "_valid_after"}, dump_valid_b, 0);
  endtask

  initial begin
    vec_t   tbl[7];
    entry_t e;
    int     got;
    logic   stalled;
    logic   reached;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'd2, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'd3, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'd4, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'd5, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'd5, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'd5, 1'b0};

    for (int i = 0; i < 32; i++) rf_a[i] = rf_val(i);
    for (int i = 0; i < 4; i++) rf_b[i] = rf_val(100 + i);
    for (int i = 0; i < 2; i++) rf_c[i] = 8'(rf_val(200 + i));

    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    is_halted_a = 1'b0; is_halted_b = 1'b0; is_halted_c = 1'b0;
    dump_ready_a = 1'b1; dump_ready_b = 1'b1; dump_ready_c = 1'b1;
    #1;
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    tick();

    // ---- instance a: reset values ----
    checkOutput("a_rst_total", total_cycle_a, 0);
    checkOutput("a_rst_valid", dump_valid_a, 0);
    checkOutput("a_rst_idx", 64'(dump_idx_a), 0);
    checkOutput("a_rst_data", dump_data_a, 0);
    checkOutput("a_rst_rf_addr", 64'(rf_addr_a), 0);
    checkOutput("a_rst_done", done_a, 0);
    checkOutput("a_rst_timed_out", timed_out_a, 0);
    checkOutput("a_rst_stall", stall_cycles_a, 0);

    // ---- instance a: 10 run cycles, halt, full dump with backpressure ----
    reset_a = 1'b0;
    repeat (10) tick();
    checkOutput("a_total_run", total_cycle_a, 10);
    checkOutput("a_run_valid", dump_valid_a, 0);
    is_halted_a = 1'b1;
    push_a();
    tick();
    checkOutput("a_load_total", total_cycle_a, 10);
    checkOutput("a_load_valid", dump_valid_a, 0);
    is_halted_a = 1'b0;
    tick();
    checkOutput("a_send_valid", dump_valid_a, 1);

    stalled = 1'b0;
    got     = 0;
    for (int c = 0; c < 200 && !done_a; c++) begin
      if (dump_valid_a) begin
        if (dump_idx_a == 5'd3 && !stalled) begin
          stalled      = 1'b1;
          dump_ready_a = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            checkOutput("a_stall_hold", {dump_valid_a, dump_idx_a, dump_data_a},
                        {1'b1, 5'd3, rf_val(3)});
          end
          dump_ready_a = 1'b1;
        end
        got++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("a_dump_idx", 64'(dump_idx_a), 64'(e.idx));
          checkOutput("a_dump_data", dump_data_a, e.data);
        end
      end
      tick();
    end
    checkOutput("a_dump_count", got, 32);
    checkOutput("a_done", done_a, 1);
    checkOutput("a_timed_out", timed_out_a, 0);
    checkOutput("a_total_frozen", total_cycle_a, 10);
    checkOutput("a_valid_after", dump_valid_a, 0);
    checkOutput("a_stall_cycles", stall_cycles_a, EXP_STALL);
    is_halted_a = 1'b1;
    repeat (3) tick();
    is_halted_a = 1'b0;
    repeat (2) tick();
    checkOutput("a_done_sticky", done_a, 1);
    checkOutput("a_total_sticky", total_cycle_a, 10);

    // ---- instance a: reset in SEND at entry 7 ----
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    repeat (2) tick();
    checkOutput("a_rerun_total", total_cycle_a, 2);
    is_halted_a = 1'b1;
    push_a();
    tick();
    is_halted_a = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      if (dump_valid_a && dump_idx_a == 5'd7) begin
        reached = 1'b1;
      end else begin
        if (dump_valid_a && sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("a2_dump_idx", 64'(dump_idx_a), 64'(e.idx));
          checkOutput("a2_dump_data", dump_data_a, e.data);
        end
        tick();
      end
    end
    checkOutput("a2_reached_7", {dump_valid_a, dump_idx_a, dump_data_a},
                {1'b1, 5'd7, rf_val(7)});
    #2;
    reset_a = 1'b1;
    #1;
    checkOutput("a2_async_out1", {dump_valid_a, dump_idx_a, dump_data_a, done_a, timed_out_a}, 0);
    checkOutput("a2_async_out2", {total_cycle_a, rf_addr_a}, 0);
    checkOutput("a2_async_stall", stall_cycles_a, 0);
    sb.delete();
    tick();
    checkOutput("a2_rst_valid", dump_valid_a, 0);
    reset_a = 1'b0;
    repeat (4) tick();
    checkOutput("a2_restart_total", total_cycle_a, 4);
    checkOutput("a2_restart_valid", dump_valid_a, 0);
    reset_a = 1'b1;

    // ---- instance b: HALT_CONFIRM=3 pattern 1,1,0,1,1,1 ----
    reset_b = 1'b0;
    push_b();
    for (int r = 0; r < 7; r++) applyStimulus(tbl[r], r);
    drain_b("b1");
    checkOutput("b1_timed_out", timed_out_b, 0);
    checkOutput("b1_total", total_cycle_b, 5);

    // ---- instance b: watchdog expiry ----
    reset_b = 1'b1;
    is_halted_b = 1'b0;
    tick();
    reset_b = 1'b0;
    repeat (19) tick();
    checkOutput("b2_total_19", total_cycle_b, 19);
    checkOutput("b2_timed_out_early", timed_out_b, 0);
    push_b();
    tick();
    checkOutput("b2_total_20", total_cycle_b, 20);
    checkOutput("b2_timed_out", timed_out_b, 1);
    checkOutput("b2_load_valid", dump_valid_b, 0);
    drain_b("b2");
    checkOutput("b2_timed_out_sticky", timed_out_b, 1);
    checkOutput("b2_total_frozen", total_cycle_b, 20);

    // ---- instance b: halt confirmed on the watchdog edge ----
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    repeat (17) tick();
    checkOutput("b3_total_17", total_cycle_b, 17);
    is_halted_b = 1'b1;
    repeat (3) tick();
    checkOutput("b3_total", total_cycle_b, 19);
    checkOutput("b3_timed_out", timed_out_b, 0);
    checkOutput("b3_load_valid", dump_valid_b, 0);
    is_halted_b = 1'b0;
    push_b();
    drain_b("b3");
    checkOutput("b3_timed_out_after", timed_out_b, 0);
    reset_b = 1'b1;

    // ---- instance c: saturation and minimum dump length ----
    reset_c = 1'b0;
    repeat (20) tick();
    checkOutput("c_total_sat", total_cycle_c, 4'hF);
    is_halted_c = 1'b1;
    tick();
    is_halted_c = 1'b0;
    checkOutput("c_load_total", total_cycle_c, 4'hF);
    tick();
    checkOutput("c_send0", {dump_valid_c, dump_idx_c, dump_data_c}, {1'b1, 1'b0, 8'(rf_val(200))});
    tick();
    checkOutput("c_load1_valid", dump_valid_c, 0);
    tick();
    checkOutput("c_send1", {dump_valid_c, dump_idx_c, dump_data_c}, {1'b1, 1'b1, 8'(rf_val(201))});
    checkOutput("c_done_early", done_c, 0);
    tick();
    checkOutput("c_done", done_c, 1);
    checkOutput("c_valid_after", dump_valid_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got time limit, expected $finish");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
